// File: rtl/stream_decoder_pkg.sv
// Shared definitions for the stream decoder: FSM state encoding, default
// parameter values and the parity helper used by the optional parity check
// (enabled with STREAM_DECODER_PARITY_EN).
package stream_decoder_pkg;

  localparam int DEF_N    = 3;
  localparam int DEF_HOLD = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // True when {code, par} carries even parity; unused code bits must be zero.
  function automatic logic even_par_ok(input logic [15:0] code, input logic par);
    return ~(^{code, par});
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational N to 2**N one-hot decoder; the exact inverse of the 8-to-3
// encoder. Instantiated twice by stream_decoder (direct and buffered paths).
module decoder_core #(
  parameter int N = 3
) (
  input  logic [N-1:0]      code,
  output logic [2**N-1:0]   onehot
);

  // One compare per output line.
  for (genvar i = 0; i < 2**N; i++) begin : g_line
    assign onehot[i] = (code == N'(i));
  end

endmodule

// File: rtl/stream_decoder.sv
// Streaming one-hot decoder. Each accepted code is shown on Y for HOLD cycles
// followed by a single all-zero gap cycle; a one-entry buffer takes the next
// code while the current one is on display.
// Optional build macro: STREAM_DECODER_PARITY_EN adds in_par / par_err and
// drops transferred codes whose {in_code, in_par} is not even parity.
module stream_decoder
  import stream_decoder_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int HOLD = DEF_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  output logic [2**N-1:0]   Y,
  output logic              y_valid,
  output logic              busy,
`ifdef STREAM_DECODER_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic [7:0]        sym_cnt
);

  localparam int OUT_W = 2**N;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic [7:0]         hold_q, hold_d;
  logic               buf_full_q, buf_full_d;
  logic [N-1:0]       buf_code_q, buf_code_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]   dec_in, dec_buf;
  logic               xfer, par_ok, accept;

  decoder_core #(.N(N)) u_dec_in  (.code(in_code),    .onehot(dec_in));
  decoder_core #(.N(N)) u_dec_buf (.code(buf_code_q), .onehot(dec_buf));

  // in_ready comes straight from the buffer flag, never from in_valid.
  assign in_ready = ~buf_full_q;
  assign xfer     = in_valid & in_ready;

`ifdef STREAM_DECODER_PARITY_EN
  logic par_err_q;
  assign par_ok  = even_par_ok(16'(in_code), in_par);
  assign par_err = par_err_q;

  // One-cycle pulse after a transfer that failed the parity check.
  always_ff @(posedge clk) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= xfer & ~par_ok;
  end
`else
  assign par_ok = 1'b1;
`endif

  // A bad-parity transfer still completes the handshake but is dropped here.
  assign accept = xfer & par_ok;

  // Next-state logic; outputs are registered so everything is computed here.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    hold_d     = hold_q;
    buf_full_d = buf_full_q;
    buf_code_d = buf_code_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        // A code buffered on the GAP->IDLE edge is popped ahead of new input;
        // in_ready is low then, so no transfer can collide with the pop.
        if (buf_full_q) begin
          y_d        = dec_buf;
          hold_d     = HOLD_LOAD;
          cnt_d      = cnt_q + 8'd1;
          buf_full_d = 1'b0;
          state_d    = S_HOLD;
        end else if (accept) begin
          y_d     = dec_in;
          hold_d  = HOLD_LOAD;
          cnt_d   = cnt_q + 8'd1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept) begin
          buf_full_d = 1'b1;
          buf_code_d = in_code;
        end
        if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          y_d     = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (buf_full_q) begin
          y_d        = dec_buf;
          hold_d     = HOLD_LOAD;
          cnt_d      = cnt_q + 8'd1;
          buf_full_d = 1'b0;
          state_d    = S_HOLD;
        end else begin
          if (accept) begin
            buf_full_d = 1'b1;
            buf_code_d = in_code;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        y_d     = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts the symbol and drops any buffered code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      y_q        <= '0;
      hold_q     <= 8'd0;
      buf_full_q <= 1'b0;
      buf_code_q <= '0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      hold_q     <= hold_d;
      buf_full_q <= buf_full_d;
      buf_code_q <= buf_code_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Y       = y_q;
  assign y_valid = (state_q == S_HOLD);
  assign busy    = (state_q != S_IDLE) | buf_full_q;
  assign sym_cnt = cnt_q;

endmodule

// File: tb/tb_stream_decoder.sv
// Directed bench for stream_decoder: HOLD=4 instance for the main scenarios,
// HOLD=1 instance for the single-cycle pulse and the sym_cnt wrap.
module tb_stream_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid0, in_ready0, y_valid0, busy0;
  logic [2:0] in_code0;
  logic [7:0] y0, sym_cnt0;
  logic       in_valid1, in_ready1, y_valid1, busy1;
  logic [2:0] in_code1;
  logic [7:0] y1, sym_cnt1;
`ifdef STREAM_DECODER_PARITY_EN
  logic in_par0, par_err0, in_par1, par_err1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_decoder #(.N(3), .HOLD(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_code(in_code0), .Y(y0), .y_valid(y_valid0), .busy(busy0),
`ifdef STREAM_DECODER_PARITY_EN
    .in_par(in_par0), .par_err(par_err0),
`endif
    .sym_cnt(sym_cnt0)
  );

  stream_decoder #(.N(3), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_code(in_code1), .Y(y1), .y_valid(y_valid1), .busy(busy1),
`ifdef STREAM_DECODER_PARITY_EN
    .in_par(in_par1), .par_err(par_err1),
`endif
    .sym_cnt(sym_cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid0 = 1'b0; in_code0 = 3'd0;
    in_valid1 = 1'b0; in_code1 = 3'd0;
`ifdef STREAM_DECODER_PARITY_EN
    in_par0 = 1'b0; in_par1 = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
  endtask

  // 8-to-3 encoder used as the loop-back source.
  function automatic logic [2:0] enc(input logic [7:0] oh);
    logic [2:0] c = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) c = 3'(i);
    return c;
  endfunction

  // Parity for a 3-bit code so the bench drives legal in_par values.
  function automatic logic par_of(input logic [2:0] c);
    return ^c;
  endfunction

  task automatic drive0(input logic v, input logic [2:0] c);
    in_valid0 = v;
    in_code0  = c;
`ifdef STREAM_DECODER_PARITY_EN
    in_par0 = par_of(c);
`endif
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (y0 !== 8'h00 || y_valid0 !== 1'b0 || busy0 !== 1'b0 || sym_cnt0 !== 8'd0 || in_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL reset: Y=%h y_valid=%b busy=%b sym_cnt=%0d in_ready=%b, want 00 0 0 0 1",
               y0, y_valid0, busy0, sym_cnt0, in_ready0);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_y [6] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive0(k == 0, 3'd5);
      step();
      checks++;
      if (y0 !== exp_y[k] || y_valid0 !== (exp_y[k] != 8'h00) || in_ready0 !== 1'b1) begin
        failures++;
        $display("FAIL single k=%0d: Y=%h y_valid=%b in_ready=%b, want %h %b 1",
                 k, y0, y_valid0, in_ready0, exp_y[k], exp_y[k] != 8'h00);
      end
    end
    checks++;
    if (sym_cnt0 !== 8'd1 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL single_end: sym_cnt=%0d busy=%b, want 1 0", sym_cnt0, busy0);
    end
  endtask

  task automatic test_back_to_back(input logic [2:0] c0, input logic [2:0] c1);
    logic [7:0] a, b;
    logic [7:0] exp_y [10];
    a = 8'h01 << c0;
    b = 8'h01 << c1;
    exp_y = '{a, a, a, a, 8'h00, b, b, b, b, 8'h00};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive0(k < 2, (k == 0) ? c0 : c1);
      step();
      checks++;
      if (y0 !== exp_y[k] || in_ready0 !== !(k >= 1 && k <= 4)) begin
        failures++;
        $display("FAIL b2b %0d,%0d k=%0d: Y=%h in_ready=%b, want %h %b",
                 c0, c1, k, y0, in_ready0, exp_y[k], !(k >= 1 && k <= 4));
      end
    end
    checks++;
    if (sym_cnt0 !== 8'd2) begin
      failures++;
      $display("FAIL b2b_cnt: sym_cnt=%0d, want 2", sym_cnt0);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] oh;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      drive0(1'b1, enc(oh));
      step();
      drive0(1'b0, 3'd0);
      checks++;
      if (y0 !== oh) begin
        failures++;
        $display("FAIL loopback i=%0d: Y=%h, want %h", i, y0, oh);
      end
      for (int w = 0; w < 5; w++) step();
    end
    checks++;
    if (sym_cnt0 !== 8'd8) begin
      failures++;
      $display("FAIL loopback_cnt: sym_cnt=%0d, want 8", sym_cnt0);
    end
  endtask

  task automatic test_mid_reset();
    logic seen = 1'b0;
    do_reset();
    drive0(1'b1, 3'd4);
    step();
    drive0(1'b1, 3'd1);
    step();
    drive0(1'b0, 3'd0);
    checks++;
    if (y0 !== 8'h10 || in_ready0 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pre: Y=%h in_ready=%b, want 10 0", y0, in_ready0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (y0 !== 8'h00 || busy0 !== 1'b0 || sym_cnt0 !== 8'd0 || in_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL midrst: Y=%h busy=%b sym_cnt=%0d in_ready=%b, want 00 0 0 1",
               y0, busy0, sym_cnt0, in_ready0);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      if (y0 !== 8'h00) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midrst_drop: buffered code shown=%b, want 0", seen);
    end
  endtask

  task automatic test_hold1_wrap();
    int n = 0;
    int t = 0;
    do_reset();
    in_valid1 = 1'b1; in_code1 = 3'd6;
`ifdef STREAM_DECODER_PARITY_EN
    in_par1 = par_of(3'd6);
`endif
    step();
    in_valid1 = 1'b0;
    checks++;
    if (y1 !== 8'h40 || y_valid1 !== 1'b1) begin
      failures++;
      $display("FAIL hold1_on: Y=%h y_valid=%b, want 40 1", y1, y_valid1);
    end
    step();
    checks++;
    if (y1 !== 8'h00 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL hold1_gap: Y=%h busy=%b, want 00 1", y1, busy1);
    end
    step();
    do_reset();
    in_valid1 = 1'b1;
    while (t < 3000 && n < 256) begin
      in_code1 = 3'(n);
`ifdef STREAM_DECODER_PARITY_EN
      in_par1 = par_of(3'(n));
`endif
      if (in_ready1) n++;
      step();
      t++;
    end
    in_valid1 = 1'b0;
    t = 0;
    while (t < 20 && busy1) begin
      step();
      t++;
    end
    checks++;
    if (n != 256 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_timeout: transfers=%0d busy=%b, want 256 0", n, busy1);
    end
    checks++;
    if (sym_cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL wrap: sym_cnt=%0d, want 0", sym_cnt1);
    end
  endtask

`ifdef STREAM_DECODER_PARITY_EN
  task automatic test_parity();
    do_reset();
    in_valid0 = 1'b1; in_code0 = 3'd3; in_par0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    checks++;
    if (par_err0 !== 1'b1 || y0 !== 8'h00 || sym_cnt0 !== 8'd0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL parity_err: par_err=%b Y=%h sym_cnt=%0d busy=%b, want 1 00 0 0",
               par_err0, y0, sym_cnt0, busy0);
    end
    step();
    checks++;
    if (par_err0 !== 1'b0 || y0 !== 8'h00) begin
      failures++;
      $display("FAIL parity_pulse: par_err=%b Y=%h, want 0 00", par_err0, y0);
    end
    in_valid0 = 1'b1; in_code0 = 3'd3; in_par0 = 1'b0;
    step();
    in_valid0 = 1'b0;
    checks++;
    if (par_err0 !== 1'b0 || y0 !== 8'h08 || sym_cnt0 !== 8'd1) begin
      failures++;
      $display("FAIL parity_ok: par_err=%b Y=%h sym_cnt=%0d, want 0 08 1",
               par_err0, y0, sym_cnt0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back(3'd0, 3'd7);
    test_back_to_back(3'd2, 3'd2);
    test_loopback();
    test_mid_reset();
    test_hold1_wrap();
`ifdef STREAM_DECODER_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
